// File: rtl/fixed_to_fp16_norm_if.sv
// ---------------------------------------------------------------------------
// fixed_to_fp16_norm_if
//   Handshake/data bundle between the MAC accumulator side and the
//   fixed-point -> fp16 normalizer.
//   master : drives start/fixed_point_in/exp_in, observes result + status
//   slave  : the normalizer (samples request, drives result + status)
//   Signals:
//     start           request conversion (accepted only when busy=0)
//     fixed_point_in  two's-complement accumulator, ACC_WIDTH bits
//     exp_in          shared 5-bit exponent
//     fp16_out        packed {sign, exp[4:0], mant[9:0]}, held
//     busy            conversion in flight
//     done            one-cycle pulse, fp16_out valid
//     overflow        saturated to +/-inf (held)
//     underflow       flushed to signed zero (held)
// ---------------------------------------------------------------------------
interface fixed_to_fp16_norm_if #(
    parameter int ACC_WIDTH = 32
);
    logic                 start;
    logic [ACC_WIDTH-1:0] fixed_point_in;
    logic [4:0]           exp_in;
    logic [15:0]          fp16_out;
    logic                 busy;
    logic                 done;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output start, fixed_point_in, exp_in,
        input  fp16_out, busy, done, overflow, underflow
    );

    modport slave (
        input  start, fixed_point_in, exp_in,
        output fp16_out, busy, done, overflow, underflow
    );
endinterface

// File: rtl/fixed_to_fp16_norm.sv
// ---------------------------------------------------------------------------
// fixed_to_fp16_norm
//   Converts the MAC's two's-complement fixed-point accumulator plus shared
//   exponent into an IEEE fp16 word. The leading one is found by shifting the
//   magnitude left one bit per cycle, then round-to-nearest-even is applied.
//   Results saturate to +/-inf on overflow and flush to signed zero on
//   underflow; no subnormals are produced.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  fixed_to_fp16_norm_if.slave (start/data in, result/status out)
// ---------------------------------------------------------------------------
module fixed_to_fp16_norm #(
    parameter int ACC_WIDTH = 32,
    parameter int FRAC_BITS = 10,
    parameter int BIAS      = 15
) (
    input logic                 clk,
    input logic                 rst,
    fixed_to_fp16_norm_if.slave bus
);
    localparam int AW      = ACC_WIDTH;
    localparam int CW      = $clog2(ACC_WIDTH);
    // Biased-exponent arithmetic needs headroom for p + exp_in + carry and
    // must go negative for the flush check.
    localparam int EW      = (CW + 4 > 8) ? CW + 4 : 8;
    localparam int EXP_MAX = 2 * BIAS + 1;   // all-ones exponent field (inf)

    typedef enum logic [1:0] {IDLE, NORM, ROUND} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] mag_q, mag_d;
    logic [CW-1:0] s_q, s_d;
    logic [4:0]    exp_q, exp_d;
    logic          sign_q, sign_d;
    logic [15:0]   fp16_q, fp16_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    // ---------------- rounding datapath (valid in ROUND) ----------------
    logic [9:0]          mant;
    logic                guard, sticky, rnd_up;
    logic [10:0]         mant_r;
    logic signed [EW-1:0] e_fin;

    // mag_q has its leading one at the MSB, so the hidden bit is dropped
    // and the next ten bits form the mantissa.
    assign mant   = mag_q[AW-2 -: 10];
    assign guard  = mag_q[AW-12];
    assign sticky = |mag_q[AW-13:0];
    assign rnd_up = guard & (sticky | mant[0]);
    assign mant_r = {1'b0, mant} + {10'd0, rnd_up};

    // E = (AW-1-s) + exp_in - FRAC_BITS, plus one if rounding carried out.
    assign e_fin = $signed(EW'(AW - 1) - EW'(s_q) + EW'(exp_q)
                           - EW'(FRAC_BITS) + EW'(mant_r[10]));

    // ---------------- next-state / datapath ----------------
    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        s_d     = s_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        fp16_d  = fp16_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sign_d  = bus.fixed_point_in[AW-1];
                    // Most-negative input negates to itself, which is the
                    // correct unsigned magnitude 2^(AW-1).
                    mag_d   = bus.fixed_point_in[AW-1]
                              ? (~bus.fixed_point_in + AW'(1))
                              : bus.fixed_point_in;
                    exp_d   = bus.exp_in;
                    s_d     = '0;
                    busy_d  = 1'b1;
                    state_d = NORM;
                end
            end

            NORM: begin
                if (mag_q == '0 || mag_q[AW-1]) begin
                    state_d = ROUND;
                end else begin
                    mag_d = mag_q << 1;
                    s_d   = s_q + CW'(1);
                end
            end

            ROUND: begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
                if (mag_q == '0) begin
                    fp16_d = 16'h0000;
                end else if (e_fin >= EW'(EXP_MAX)) begin
                    fp16_d = {sign_q, 5'h1F, 10'h000};
                    ovf_d  = 1'b1;
                end else if (e_fin <= EW'(0)) begin
                    fp16_d = {sign_q, 15'h0000};
                    unf_d  = 1'b1;
                end else begin
                    fp16_d = {sign_q, e_fin[4:0], mant_r[9:0]};
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mag_q   <= '0;
            s_q     <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            fp16_q  <= 16'h0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            s_q     <= s_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            fp16_q  <= fp16_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.fp16_out  = fp16_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;

endmodule

// File: tb/tb_fixed_to_fp16_norm.sv
// ---------------------------------------------------------------------------
// tb_fixed_to_fp16_norm
//   Directed-vector bench for fixed_to_fp16_norm with hand-computed fp16
//   results, latencies and flags.
// ---------------------------------------------------------------------------
module tb_fixed_to_fp16_norm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs   = 0;
    int   checks = 0;

    fixed_to_fp16_norm_if #(.ACC_WIDTH(32)) bus ();

    fixed_to_fp16_norm #(
        .ACC_WIDTH(32),
        .FRAC_BITS(10),
        .BIAS     (15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive a request in the current cycle; returns 1 time unit after the
    // accepting edge (edge 0).
    task automatic issue(input logic [31:0] fx, input logic [4:0] ex);
        bus.start          = 1'b1;
        bus.fixed_point_in = fx;
        bus.exp_in         = ex;
        @(posedge clk); #1;
        bus.start          = 1'b0;
        bus.fixed_point_in = 32'hDEAD_BEEF;   // only valid in start cycle
        bus.exp_in         = 5'h1F;
        chk("busy_after_start", 32'(bus.busy), 1);
        chk("no_done_after_start", 32'(bus.done), 0);
    endtask

    // Count edges after edge 0 until done; already = edges consumed so far.
    task automatic wait_done(input string tag, input int already,
                             input int lat, input logic [15:0] fp,
                             input logic ovf, input logic unf);
        int n;
        bit seen;
        n    = already;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (bus.done) seen = 1'b1;
        end
        chk({tag, "_done"}, 32'(seen), 1);
        if (seen) begin
            chk({tag, "_lat"}, 32'(n), 32'(lat));
            chk({tag, "_fp16"}, 32'(bus.fp16_out), 32'(fp));
            chk({tag, "_ovf"}, 32'(bus.overflow), 32'(ovf));
            chk({tag, "_unf"}, 32'(bus.underflow), 32'(unf));
            chk({tag, "_busy"}, 32'(bus.busy), 0);
        end
    endtask

    task automatic conv(input string tag, input logic [31:0] fx,
                        input logic [4:0] ex, input logic [15:0] fp,
                        input int lat, input logic ovf, input logic unf);
        @(negedge clk);
        issue(fx, ex);
        wait_done(tag, 0, lat, fp, ovf, unf);
    endtask

    initial begin
        int  nd;
        bus.start          = 1'b0;
        bus.fixed_point_in = '0;
        bus.exp_in         = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fp16", 32'(bus.fp16_out), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        chk("rst_unf", 32'(bus.underflow), 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic values
        conv("one",   32'h0000_0400, 5'd15, 16'h3C00, 23, 1'b0, 1'b0);
        conv("neg",   32'hFFFF_FA00, 5'd15, 16'hBE00, 23, 1'b0, 1'b0);

        // Zero, then back-to-back start in the done cycle
        conv("zero",  32'h0000_0000, 5'd7,  16'h0000, 2,  1'b0, 1'b0);
        issue(32'h0000_0801, 5'd15);
        wait_done("b2b_tie_even", 0, 22, 16'h4000, 1'b0, 1'b0);

        // start while busy is ignored
        @(negedge clk);
        issue(32'h0000_0400, 5'd15);
        @(posedge clk); #1;
        bus.start          = 1'b1;
        bus.fixed_point_in = 32'h0000_0FFF;
        bus.exp_in         = 5'd3;
        @(posedge clk); #1;
        bus.start          = 1'b0;
        wait_done("ignore_busy", 2, 23, 16'h3C00, 1'b0, 1'b0);

        // Rounding
        conv("tie_up", 32'h0000_0803, 5'd15, 16'h4002, 22, 1'b0, 1'b0);
        conv("carry",  32'h0000_0FFF, 5'd15, 16'h4400, 22, 1'b0, 1'b0);

        // Saturation and flush
        conv("ovf_pos", 32'h7FFF_FFFF, 5'd31, 16'h7C00, 3,  1'b1, 1'b0);
        conv("ovf_neg", 32'h8000_0000, 5'd31, 16'hFC00, 2,  1'b1, 1'b0);
        conv("unf",     32'h0000_0001, 5'd0,  16'h0000, 33, 1'b0, 1'b1);

        // Reset mid-conversion (underflow flag is still high going in)
        @(negedge clk);
        issue(32'h0000_0001, 5'd15);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_fp16", 32'(bus.fp16_out), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_done", 32'(bus.done), 0);
        chk("midrst_unf", 32'(bus.underflow), 0);
        chk("midrst_ovf", 32'(bus.overflow), 0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) nd++;
        end
        chk("midrst_no_done", 32'(nd), 0);
        conv("after_rst", 32'h0000_0001, 5'd15, 16'h1400, 33, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
